// File: rtl/adam_axil_pause.sv
// rtl/adam_axil_pause.sv - AXI-Lite pass-through gate answering the ADAM_PAUSE req/ack handshake
module adam_axil_pause #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_TRANS  = 4,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause_req,
    output logic                  pause_ack,

    input  logic [ADDR_WIDTH-1:0] slv_aw_addr,
    input  logic [2:0]            slv_aw_prot,
    input  logic                  slv_aw_valid,
    output logic                  slv_aw_ready,
    input  logic [DATA_WIDTH-1:0] slv_w_data,
    input  logic [STRB_WIDTH-1:0] slv_w_strb,
    input  logic                  slv_w_valid,
    output logic                  slv_w_ready,
    output logic [1:0]            slv_b_resp,
    output logic                  slv_b_valid,
    input  logic                  slv_b_ready,
    input  logic [ADDR_WIDTH-1:0] slv_ar_addr,
    input  logic [2:0]            slv_ar_prot,
    input  logic                  slv_ar_valid,
    output logic                  slv_ar_ready,
    output logic [DATA_WIDTH-1:0] slv_r_data,
    output logic [1:0]            slv_r_resp,
    output logic                  slv_r_valid,
    input  logic                  slv_r_ready,

    output logic [ADDR_WIDTH-1:0] mst_aw_addr,
    output logic [2:0]            mst_aw_prot,
    output logic                  mst_aw_valid,
    input  logic                  mst_aw_ready,
    output logic [DATA_WIDTH-1:0] mst_w_data,
    output logic [STRB_WIDTH-1:0] mst_w_strb,
    output logic                  mst_w_valid,
    input  logic                  mst_w_ready,
    input  logic [1:0]            mst_b_resp,
    input  logic                  mst_b_valid,
    output logic                  mst_b_ready,
    output logic [ADDR_WIDTH-1:0] mst_ar_addr,
    output logic [2:0]            mst_ar_prot,
    output logic                  mst_ar_valid,
    input  logic                  mst_ar_ready,
    input  logic [DATA_WIDTH-1:0] mst_r_data,
    input  logic [1:0]            mst_r_resp,
    input  logic                  mst_r_valid,
    output logic                  mst_r_ready
);

    localparam int CW = $clog2(MAX_TRANS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_TRANS);

    typedef enum logic [1:0] {
        PAUSED,
        RUNNING,
        DRAINING
    } state_t;

    state_t        state;
    logic [CW-1:0] wr_out;
    logic [CW-1:0] rd_out;
    logic [CW-1:0] w_owed;

    logic aw_gate, ar_gate, w_gate;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic idle;

    // Address gates depend only on registered state, never on a ready.
    assign aw_gate = (state == RUNNING) && (wr_out < MAX_CNT);
    assign ar_gate = (state == RUNNING) && (rd_out < MAX_CNT);

    assign mst_aw_addr  = slv_aw_addr;
    assign mst_aw_prot  = slv_aw_prot;
    assign mst_aw_valid = slv_aw_valid & aw_gate;
    assign slv_aw_ready = mst_aw_ready & aw_gate;
    assign aw_hs        = mst_aw_valid & mst_aw_ready;

    // Data may ride along with its own address beat, but never run ahead of it.
    assign w_gate      = (w_owed != '0) | aw_hs;
    assign mst_w_data  = slv_w_data;
    assign mst_w_strb  = slv_w_strb;
    assign mst_w_valid = slv_w_valid & w_gate;
    assign slv_w_ready = mst_w_ready & w_gate;
    assign w_hs        = mst_w_valid & mst_w_ready;

    assign slv_b_resp  = mst_b_resp;
    assign slv_b_valid = mst_b_valid;
    assign mst_b_ready = slv_b_ready;
    assign b_hs        = mst_b_valid & mst_b_ready;

    assign mst_ar_addr  = slv_ar_addr;
    assign mst_ar_prot  = slv_ar_prot;
    assign mst_ar_valid = slv_ar_valid & ar_gate;
    assign slv_ar_ready = mst_ar_ready & ar_gate;
    assign ar_hs        = mst_ar_valid & mst_ar_ready;

    assign slv_r_data  = mst_r_data;
    assign slv_r_resp  = mst_r_resp;
    assign slv_r_valid = mst_r_valid;
    assign mst_r_ready = slv_r_ready;
    assign r_hs        = mst_r_valid & mst_r_ready;

    assign idle = (wr_out == '0) && (rd_out == '0) && (w_owed == '0);

    function automatic logic [CW-1:0] bump(input logic [CW-1:0] cnt, input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return cnt + CW'(1);
            2'b01:   return cnt - CW'(1);
            default: return cnt;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PAUSED;
            pause_ack <= 1'b1;
            wr_out    <= '0;
            rd_out    <= '0;
            w_owed    <= '0;
        end else begin
            wr_out <= bump(wr_out, aw_hs, b_hs);
            rd_out <= bump(rd_out, ar_hs, r_hs);
            w_owed <= bump(w_owed, aw_hs, w_hs);
            case (state)
                PAUSED: begin
                    if (!pause_req) begin
                        state     <= RUNNING;
                        pause_ack <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (pause_req) begin
                        state <= DRAINING;
                    end
                end
                DRAINING: begin
                    // An aborted request wins over a drain that happens to finish now.
                    if (!pause_req) begin
                        state <= RUNNING;
                    end else if (idle) begin
                        state     <= PAUSED;
                        pause_ack <= 1'b1;
                    end
                end
                default: begin
                    state     <= PAUSED;
                    pause_ack <= 1'b1;
                end
            endcase
        end
    end

    wr_overflow:  assert property (@(posedge clk) disable iff (rst) !(aw_hs && !b_hs && wr_out == MAX_CNT));
    wr_underflow: assert property (@(posedge clk) disable iff (rst) !(b_hs && !aw_hs && wr_out == '0));
    rd_overflow:  assert property (@(posedge clk) disable iff (rst) !(ar_hs && !r_hs && rd_out == MAX_CNT));
    rd_underflow: assert property (@(posedge clk) disable iff (rst) !(r_hs && !ar_hs && rd_out == '0));
    wo_overflow:  assert property (@(posedge clk) disable iff (rst) !(aw_hs && !w_hs && w_owed == MAX_CNT));
    wo_underflow: assert property (@(posedge clk) disable iff (rst) !(w_hs && !aw_hs && w_owed == '0));

endmodule

// File: tb/tb_adam_axil_pause.sv
// tb/tb_adam_axil_pause.sv - directed and random check of adam_axil_pause against a transaction-count model
module tb_adam_axil_pause;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MT = 4;

    logic clk = 1'b0;
    logic rst;
    logic pause_req, pause_ack;

    logic [AW-1:0] slv_aw_addr, slv_ar_addr, mst_aw_addr, mst_ar_addr;
    logic [2:0]    slv_aw_prot, slv_ar_prot, mst_aw_prot, mst_ar_prot;
    logic          slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
    logic [DW-1:0] slv_w_data, mst_w_data, slv_r_data, mst_r_data;
    logic [SW-1:0] slv_w_strb, mst_w_strb;
    logic          slv_w_valid, slv_w_ready, mst_w_valid, mst_w_ready;
    logic [1:0]    slv_b_resp, mst_b_resp, slv_r_resp, mst_r_resp;
    logic          slv_b_valid, slv_b_ready, mst_b_valid, mst_b_ready;
    logic          slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
    logic          slv_r_valid, slv_r_ready, mst_r_valid, mst_r_ready;

    int checks = 0;
    int errors = 0;

    adam_axil_pause #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_TRANS(MT)) dut (
        .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
        .slv_aw_addr(slv_aw_addr), .slv_aw_prot(slv_aw_prot), .slv_aw_valid(slv_aw_valid), .slv_aw_ready(slv_aw_ready),
        .slv_w_data(slv_w_data), .slv_w_strb(slv_w_strb), .slv_w_valid(slv_w_valid), .slv_w_ready(slv_w_ready),
        .slv_b_resp(slv_b_resp), .slv_b_valid(slv_b_valid), .slv_b_ready(slv_b_ready),
        .slv_ar_addr(slv_ar_addr), .slv_ar_prot(slv_ar_prot), .slv_ar_valid(slv_ar_valid), .slv_ar_ready(slv_ar_ready),
        .slv_r_data(slv_r_data), .slv_r_resp(slv_r_resp), .slv_r_valid(slv_r_valid), .slv_r_ready(slv_r_ready),
        .mst_aw_addr(mst_aw_addr), .mst_aw_prot(mst_aw_prot), .mst_aw_valid(mst_aw_valid), .mst_aw_ready(mst_aw_ready),
        .mst_w_data(mst_w_data), .mst_w_strb(mst_w_strb), .mst_w_valid(mst_w_valid), .mst_w_ready(mst_w_ready),
        .mst_b_resp(mst_b_resp), .mst_b_valid(mst_b_valid), .mst_b_ready(mst_b_ready),
        .mst_ar_addr(mst_ar_addr), .mst_ar_prot(mst_ar_prot), .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
        .mst_r_data(mst_r_data), .mst_r_resp(mst_r_resp), .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready)
    );

    always #5 clk = ~clk;

    // Model: the pause phase plus plain counts of what is in flight downstream.
    typedef enum {M_PAUSED, M_RUNNING, M_DRAINING} mphase_t;
    mphase_t m_phase = M_PAUSED;
    bit m_ack = 1'b1;
    int m_wr = 0, m_rd = 0, m_wo = 0, m_bable = 0;
    bit started = 1'b0;
    bit e_aw, e_w, e_b, e_ar, e_r, m_idle;

    function automatic bit aw_may_pass();
        return (m_phase == M_RUNNING) && (m_wr < MT);
    endfunction

    function automatic bit ar_may_pass();
        return (m_phase == M_RUNNING) && (m_rd < MT);
    endfunction

    function automatic bit w_may_pass();
        return (m_wo > 0) || (slv_aw_valid && mst_aw_ready && aw_may_pass());
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = M_PAUSED;
            m_ack   = 1'b1;
            m_wr = 0; m_rd = 0; m_wo = 0; m_bable = 0;
        end else begin
            e_aw   = slv_aw_valid && mst_aw_ready && aw_may_pass();
            e_w    = slv_w_valid && mst_w_ready && w_may_pass();
            e_b    = mst_b_valid && slv_b_ready;
            e_ar   = slv_ar_valid && mst_ar_ready && ar_may_pass();
            e_r    = mst_r_valid && slv_r_ready;
            m_idle = (m_wr == 0) && (m_rd == 0) && (m_wo == 0);
            if (m_phase == M_PAUSED && !pause_req) begin
                m_phase = M_RUNNING; m_ack = 1'b0;
            end else if (m_phase == M_RUNNING && pause_req) begin
                m_phase = M_DRAINING;
            end else if (m_phase == M_DRAINING && !pause_req) begin
                m_phase = M_RUNNING;
            end else if (m_phase == M_DRAINING && m_idle) begin
                m_phase = M_PAUSED; m_ack = 1'b1;
            end
            m_wr    += int'(e_aw) - int'(e_b);
            m_rd    += int'(e_ar) - int'(e_r);
            m_wo    += int'(e_aw) - int'(e_w);
            m_bable += int'(e_w) - int'(e_b);
        end
        started = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("ack", 64'(pause_ack), 64'(m_ack));
            chk("mst_aw_valid", 64'(mst_aw_valid), 64'(slv_aw_valid && aw_may_pass()));
            chk("slv_aw_ready", 64'(slv_aw_ready), 64'(mst_aw_ready && aw_may_pass()));
            chk("mst_ar_valid", 64'(mst_ar_valid), 64'(slv_ar_valid && ar_may_pass()));
            chk("slv_ar_ready", 64'(slv_ar_ready), 64'(mst_ar_ready && ar_may_pass()));
            chk("mst_w_valid", 64'(mst_w_valid), 64'(slv_w_valid && w_may_pass()));
            chk("slv_w_ready", 64'(slv_w_ready), 64'(mst_w_ready && w_may_pass()));
            chk("b_pass", 64'({slv_b_valid, mst_b_ready, slv_b_resp}), 64'({mst_b_valid, slv_b_ready, mst_b_resp}));
            chk("r_pass", 64'({slv_r_valid, mst_r_ready, slv_r_resp, slv_r_data}), 64'({mst_r_valid, slv_r_ready, mst_r_resp, mst_r_data}));
            chk("aw_payload", 64'({mst_aw_prot, mst_aw_addr}), 64'({slv_aw_prot, slv_aw_addr}));
            chk("ar_payload", 64'({mst_ar_prot, mst_ar_addr}), 64'({slv_ar_prot, slv_ar_addr}));
            chk("w_payload", 64'({mst_w_strb, mst_w_data}), 64'({slv_w_strb, slv_w_data}));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        slv_aw_valid = 0; slv_w_valid = 0; slv_b_ready = 0; slv_ar_valid = 0; slv_r_ready = 0;
        mst_aw_ready = 0; mst_w_ready = 0; mst_b_valid = 0; mst_ar_ready = 0; mst_r_valid = 0;
    endtask

    initial begin
        rst = 1; pause_req = 0; clr();
        slv_aw_addr = 0; slv_aw_prot = 0; slv_ar_addr = 0; slv_ar_prot = 0;
        slv_w_data = 0; slv_w_strb = 0; mst_b_resp = 0; mst_r_data = 0; mst_r_resp = 0;
        slv_aw_valid = 1; mst_aw_ready = 1; slv_ar_valid = 1; mst_ar_ready = 1;
        cyc(); cyc();
        @(negedge clk);
        chk("t1_rst_ack", 64'(pause_ack), 64'd1);
        chk("t1_rst_aw_valid", 64'(mst_aw_valid), 64'd0);
        chk("t1_rst_ar_ready", 64'(slv_ar_ready), 64'd0);
        cyc(); rst = 0; clr();
        @(negedge clk); chk("t1_ack_hold", 64'(pause_ack), 64'd1);
        cyc();
        @(negedge clk); chk("t1_ack_fall", 64'(pause_ack), 64'd0);

        // Single write through an open path
        cyc();
        slv_aw_addr = 32'h0000_1000; slv_aw_valid = 1; mst_aw_ready = 1;
        slv_w_data = 32'hDEAD_BEEF; slv_w_strb = 4'hF; slv_w_valid = 1; mst_w_ready = 1;
        @(negedge clk);
        chk("t1_aw_valid", 64'(mst_aw_valid), 64'd1);
        chk("t1_aw_addr", 64'(mst_aw_addr), 64'h1000);
        chk("t1_w_data", 64'(mst_w_data), 64'hDEADBEEF);
        cyc(); clr(); mst_b_valid = 1; mst_b_resp = 2'b00; slv_b_ready = 1;
        @(negedge clk);
        chk("t1_b_valid", 64'(slv_b_valid), 64'd1);
        chk("t1_b_resp", 64'(slv_b_resp), 64'd0);
        cyc(); clr();

        // Read limit: four reads fill the window
        slv_ar_valid = 1; mst_ar_ready = 1;
        for (int i = 0; i < 4; i++) begin
            slv_ar_addr = 32'h100 + 32'(i * 4);
            @(negedge clk); chk("t2_ar_accept", 64'(slv_ar_ready), 64'd1);
            cyc();
        end
        @(negedge clk); chk("t2_ar_full", 64'(slv_ar_ready), 64'd0);
        cyc();
        mst_r_valid = 1; slv_r_ready = 1; mst_r_data = 32'hCAFE_0001; mst_r_resp = 2'b10;
        @(negedge clk);
        chk("t2_ar_full_r", 64'(slv_ar_ready), 64'd0);
        chk("t2_r_resp", 64'(slv_r_resp), 64'd2);
        cyc(); mst_r_valid = 0;
        @(negedge clk); chk("t2_ar_reopen", 64'(slv_ar_ready), 64'd1);
        cyc(); slv_ar_valid = 0; mst_r_valid = 1; mst_r_resp = 2'b00;
        repeat (4) cyc();
        clr();

        // Drain two writes while paused
        slv_aw_valid = 1; mst_aw_ready = 1; slv_w_valid = 1; mst_w_ready = 1;
        cyc(); cyc(); clr();
        pause_req = 1;
        cyc(); slv_aw_valid = 1; mst_aw_ready = 1;
        @(negedge clk);
        chk("t3_aw_closed", 64'(mst_aw_valid), 64'd0);
        chk("t3_ack_low", 64'(pause_ack), 64'd0);
        cyc(); mst_b_valid = 1; slv_b_ready = 1;
        cyc();
        @(negedge clk); chk("t3_ack_b1", 64'(pause_ack), 64'd0);
        cyc(); mst_b_valid = 0;
        @(negedge clk); chk("t3_ack_wr0", 64'(pause_ack), 64'd0);
        cyc();
        @(negedge clk); chk("t3_ack_rise", 64'(pause_ack), 64'd1);
        cyc(); pause_req = 0; slv_aw_valid = 0;
        cyc();
        @(negedge clk); chk("t3_ack_resume", 64'(pause_ack), 64'd0);
        cyc(); clr();

        // W offered ahead of its AW
        slv_w_valid = 1; mst_w_ready = 1; slv_w_data = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk); chk("t4_w_blocked", 64'(mst_w_valid), 64'd0);
            cyc();
        end
        slv_aw_valid = 1; mst_aw_ready = 1;
        @(negedge clk);
        chk("t4_w_pass", 64'(mst_w_valid), 64'd1);
        chk("t4_aw_pass", 64'(mst_aw_valid), 64'd1);
        cyc(); clr(); mst_b_valid = 1; slv_b_ready = 1; slv_w_valid = 1; mst_w_ready = 1;
        @(negedge clk); chk("t4_w_owed_zero", 64'(mst_w_valid), 64'd0);
        cyc(); clr();

        // Aborted pause with a read outstanding
        slv_ar_valid = 1; mst_ar_ready = 1;
        cyc(); clr(); pause_req = 1;
        cyc(); slv_ar_valid = 1; mst_ar_ready = 1;
        @(negedge clk); chk("t5_ar_held", 64'(slv_ar_ready), 64'd0);
        cyc(); pause_req = 0;
        @(negedge clk); chk("t5_ack_low", 64'(pause_ack), 64'd0);
        cyc();
        @(negedge clk);
        chk("t5_ar_resume", 64'(slv_ar_ready), 64'd1);
        chk("t5_ack_still_low", 64'(pause_ack), 64'd0);
        cyc(); clr(); mst_r_valid = 1; slv_r_ready = 1;
        cyc(); cyc(); clr();

        // Idle pause: two-cycle ack, nothing admitted while paused
        pause_req = 1;
        @(negedge clk); chk("t6_ack_c0", 64'(pause_ack), 64'd0);
        cyc();
        @(negedge clk); chk("t6_ack_c1", 64'(pause_ack), 64'd0);
        cyc();
        @(negedge clk); chk("t6_ack_c2", 64'(pause_ack), 64'd1);
        slv_aw_valid = 1; mst_aw_ready = 1; slv_ar_valid = 1; mst_ar_ready = 1; slv_w_valid = 1; mst_w_ready = 1;
        repeat (3) begin
            cyc();
            @(negedge clk);
            chk("t6_aw_blocked", 64'(slv_aw_ready), 64'd0);
            chk("t6_ar_blocked", 64'(slv_ar_ready), 64'd0);
        end
        cyc(); pause_req = 0;
        cyc();
        @(negedge clk);
        chk("t6_ack_drop", 64'(pause_ack), 64'd0);
        chk("t6_aw_open", 64'(slv_aw_ready), 64'd1);
        cyc(); clr(); mst_b_valid = 1; slv_b_ready = 1; mst_r_valid = 1; slv_r_ready = 1;
        cyc(); clr();

        // Random traffic with random pause/abort requests
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) pause_req = ~pause_req;
            slv_aw_valid = 1'($urandom_range(0, 1)); slv_aw_addr = $urandom; slv_aw_prot = 3'($urandom_range(0, 7));
            slv_w_valid  = 1'($urandom_range(0, 1)); slv_w_data  = $urandom; slv_w_strb  = 4'($urandom_range(0, 15));
            slv_ar_valid = 1'($urandom_range(0, 1)); slv_ar_addr = $urandom; slv_ar_prot = 3'($urandom_range(0, 7));
            slv_b_ready  = 1'($urandom_range(0, 1)); slv_r_ready = 1'($urandom_range(0, 1));
            mst_aw_ready = 1'($urandom_range(0, 1)); mst_w_ready = 1'($urandom_range(0, 1));
            mst_ar_ready = 1'($urandom_range(0, 1));
            mst_b_valid  = (m_bable > 0) && ($urandom_range(0, 2) != 0);
            mst_b_resp   = 2'($urandom_range(0, 3));
            mst_r_valid  = (m_rd > 0) && ($urandom_range(0, 2) != 0);
            mst_r_resp   = 2'($urandom_range(0, 3)); mst_r_data = $urandom;
            cyc();
        end
        clr();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
